pck_inject_sched: RTL and testbench
===================================

Name: pck_inject_sched

Overview:
- Injection-side scheduler for one router local port.
- Shares a single header-flit generator and injection link among N local packet sources using round-robin arbitration.
- Locks the winner for a whole packet and sequences header, body and tail flits.
- Gates every flit on per-VC credit counters fed by the router's credit return.
- Outputs the header fields in the form the header-flit generator consumes, plus flit write, header and tail flags, VC and payload.

Parameters:
N, 4, number of requesting sources (>=2)
V, 2, virtual channels per port
B, 4, buffer depth per VC (initial credit)
EAw, 8, endpoint address width
DAw, 8, destination address width
Cw, 1, message class width
Fpay, 32, flit payload width
LENw, 8, packet length field width (flits)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0)
src_e_addr  in  EAw  this endpoint's address, static
req  in  N  per-source packet request
req_len  in  N*LENw  packet length in flits, per source
req_dest  in  N*DAw  destination address, per source
req_class  in  N*Cw  class, per source
req_vc  in  N*V  one-hot VC select, per source
req_data  in  N*Fpay  current-flit payload, per source
credit_in  in  V  one credit returned per set bit
ack  out  N  one-cycle pulse when the source's descriptor is latched
data_rd  out  N  one-cycle pulse when the source's current payload is consumed
hdr_src_e_addr  out  EAw  to header generator
hdr_dest  out  DAw  latched destination
hdr_class  out  Cw  latched class
flit_vc  out  V  latched one-hot VC
flit_wr  out  1  flit valid this cycle
flit_hdr  out  1  flit is a header
flit_tail  out  1  flit is a tail
flit_payload  out  Fpay  payload of the owner source
busy  out  1  state is not IDLE
credit_cnt  out  V*(log2(B)+1)  credit counters, for debug

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, RR pointer=0, all credit counters=B, latched descriptor=0.
  - All outputs 0 except credit_cnt=B per VC.
  - Reset mid-packet aborts the packet; no tail is emitted.
- States: IDLE, HDR, BODY.
- IDLE:
  - If any req bit is set, pick the first set bit at or above the RR pointer, wrapping.
  - At that edge, latch owner id, dest, class, vc and len, with len==0 coerced to 1.
  - Pulse ack[owner]; go to HDR.
  - No flit is emitted in IDLE. Arbitration latency is 1 cycle.
- HDR: flit_wr = credit_cnt[vc] != 0, combinational from registers only.
  - When flit_wr: flit_hdr=1, data_rd[owner]=1.
  - If len==1: flit_tail=1, next state IDLE.
  - Otherwise: remaining=len-1, next state BODY.
  - With no credit: hold state, flit_wr=0, no data_rd.
- BODY: when credit is available, flit_wr=1, flit_hdr=0, data_rd[owner]=1.
  - flit_tail=1 when remaining==1, then next state IDLE; otherwise decrement remaining.
  - At most one flit per cycle.
- RR pointer is set to (owner+1) mod N on the edge the tail is written, not at grant.
- req[owner] dropping mid-packet is ignored; the packet always completes its latched len.
- The source holds req_data stable until data_rd. flit_payload = req_data[owner] (combinational mux).
- hdr_* and flit_vc hold the latched values from grant until the next grant.
- Credit counter per VC, width log2(B)+1:
  - next = cnt - (flit_wr & vc bit) + credit_in bit.
  - Simultaneous decrement and increment leaves the count unchanged.
  - Never exceeds B. A credit_in arriving with cnt==B is a protocol error: saturate and flag via a simulation-only assertion.
- No back-to-back packets: at least one IDLE cycle between a tail and the next header. Throughput is len flits per len+1 cycles with full credit.
- Latency: req to header flit_wr is 2 cycles with credit available.

Test Plan:
- Single-flit packet: req[0]=1, len=1, dest=0x12, vc=01, credit B=4 → ack[0] at cycle 1; cycle 2 flit_wr=1, flit_hdr=1, flit_tail=1, hdr_dest=0x12, data_rd[0]=1; credit_cnt[0]=3; back to IDLE.
- Credit stall: len=3 on vc=10, credit_cnt[1] preset to 1 by consuming 3 credits → header emitted, then flit_wr=0 until credit_in=10 pulses. Body and tail each follow one cycle after each returned credit. Tail carries flit_tail=1.
- RR fairness: req=1011 continuously, len=2 each → grant order 0,1,3,0,1,3; each packet is HDR then tail with no interleaving; pointer advances on tail.
- Simultaneous credit: flit_wr on vc0 with credit_in[0]=1 in the same cycle → credit_cnt[0] unchanged. len=0 request → treated as single flit with flit_hdr=flit_tail=1.
- Reset mid-packet: len=5, reset=0 after the 2nd flit → next cycle busy=0, flit_wr=0, credits=B, RR pointer=0. After release, req[2] alone → granted normally.
- Drop request mid-packet: req[1] deasserted after ack, len=4 → all 4 flits still emitted, with data_rd[1] pulsed 4 times.

Source files
------------

// File: rtl/pck_inject_sched.sv
// Injection-side scheduler for one router local port: round-robin grant among N
// sources, whole-packet ownership, header/body/tail sequencing gated by per-VC credits.
module pck_inject_sched #(
  parameter int N    = 4,
  parameter int V    = 2,
  parameter int B    = 4,
  parameter int EAw  = 8,
  parameter int DAw  = 8,
  parameter int Cw   = 1,
  parameter int Fpay = 32,
  parameter int LENw = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [EAw-1:0]                  src_e_addr,
  input  logic [N-1:0]                    req,
  input  logic [N*LENw-1:0]               req_len,
  input  logic [N*DAw-1:0]                req_dest,
  input  logic [N*Cw-1:0]                 req_class,
  input  logic [N*V-1:0]                  req_vc,
  input  logic [N*Fpay-1:0]               req_data,
  input  logic [V-1:0]                    credit_in,
  output logic [N-1:0]                    ack,
  output logic [N-1:0]                    data_rd,
  output logic [EAw-1:0]                  hdr_src_e_addr,
  output logic [DAw-1:0]                  hdr_dest,
  output logic [Cw-1:0]                   hdr_class,
  output logic [V-1:0]                    flit_vc,
  output logic                            flit_wr,
  output logic                            flit_hdr,
  output logic                            flit_tail,
  output logic [Fpay-1:0]                 flit_payload,
  output logic                            busy,
  output logic [V*($clog2(B)+1)-1:0]      credit_cnt
);

  localparam int CW = $clog2(B) + 1;
  localparam int NW = $clog2(N);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

  state_e                  state_q, state_d;
  logic [NW-1:0]           rr_q, rr_d;
  logic [NW-1:0]           owner_q, owner_d;
  logic [EAw-1:0]          eaddr_q, eaddr_d;
  logic [DAw-1:0]          dest_q, dest_d;
  logic [Cw-1:0]           class_q, class_d;
  logic [V-1:0]            vc_q, vc_d;
  logic [LENw-1:0]         remaining_q, remaining_d;
  logic [V-1:0][CW-1:0]    credit_q, credit_d;

  logic                    grant_valid;
  logic [NW-1:0]           grant_id;
  logic [LENw-1:0]         grant_len;
  logic                    has_credit;
  logic [NW-1:0]           next_rr;

  function automatic logic [NW-1:0] wrap_idx(input logic [NW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return NW'(s);
  endfunction

  // Lowest offset from the pointer wins, so scan from the far end and let nearer hits overwrite.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap_idx(rr_q, i)]) begin
        grant_valid = 1'b1;
        grant_id    = wrap_idx(rr_q, i);
      end
    end
  end

  assign grant_len = req_len[grant_id*LENw +: LENw];
  assign next_rr   = (owner_q == NW'(N - 1)) ? '0 : owner_q + NW'(1);

  always_comb begin
    has_credit = 1'b0;
    for (int v = 0; v < V; v++) begin
      if (vc_q[v] && credit_q[v] != '0) has_credit = 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    eaddr_d     = eaddr_q;
    dest_d      = dest_q;
    class_d     = class_q;
    vc_d        = vc_q;
    remaining_d = remaining_q;
    ack         = '0;
    data_rd     = '0;
    flit_wr     = 1'b0;
    flit_hdr    = 1'b0;
    flit_tail   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ack is held off while reset is asserted, since nothing gets latched on that edge.
        if (reset && grant_valid) begin
          owner_d        = grant_id;
          eaddr_d        = src_e_addr;
          dest_d         = req_dest[grant_id*DAw +: DAw];
          class_d        = req_class[grant_id*Cw +: Cw];
          vc_d           = req_vc[grant_id*V +: V];
          remaining_d    = (grant_len == '0) ? LENw'(1) : grant_len;
          ack[grant_id]  = 1'b1;
          state_d        = HDR;
        end
      end
      HDR, BODY: begin
        if (has_credit) begin
          flit_wr          = 1'b1;
          flit_hdr         = (state_q == HDR);
          data_rd[owner_q] = 1'b1;
          if (remaining_q == LENw'(1)) begin
            flit_tail = 1'b1;
            rr_d      = next_rr;
            state_d   = IDLE;
          end else begin
            remaining_d = remaining_q - LENw'(1);
            state_d     = BODY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A returned credit and a consumed credit on the same VC cancel out.
  always_comb begin
    credit_d = credit_q;
    for (int v = 0; v < V; v++) begin
      if (flit_wr && vc_q[v] && !credit_in[v]) begin
        credit_d[v] = credit_q[v] - CW'(1);
      end else if (credit_in[v] && !(flit_wr && vc_q[v]) && credit_q[v] != CW'(B)) begin
        credit_d[v] = credit_q[v] + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      eaddr_q     <= '0;
      dest_q      <= '0;
      class_q     <= '0;
      vc_q        <= '0;
      remaining_q <= '0;
      credit_q    <= {V{CW'(B)}};
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      eaddr_q     <= eaddr_d;
      dest_q      <= dest_d;
      class_q     <= class_d;
      vc_q        <= vc_d;
      remaining_q <= remaining_d;
      credit_q    <= credit_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign flit_payload   = busy ? req_data[owner_q*Fpay +: Fpay] : '0;
  assign hdr_src_e_addr = eaddr_q;
  assign hdr_dest       = dest_q;
  assign hdr_class      = class_q;
  assign flit_vc        = vc_q;
  assign credit_cnt     = credit_q;

`ifndef SYNTHESIS
  // A credit returned to a full counter means the downstream buffer over-reported space.
  for (genvar gv = 0; gv < V; gv++) begin : g_credit_chk
    credit_overflow_a: assert property (@(posedge clk) disable iff (!reset)
      !(credit_in[gv] && !(flit_wr && vc_q[gv]) && credit_q[gv] == CW'(B)));
  end
`endif

endmodule

// File: tb/tb_pck_inject_sched.sv
// Bench for pck_inject_sched: directed vector table, hand-written corner sequences,
// then randomized traffic against a packet-level reference model.
module tb_pck_inject_sched;
  localparam int N    = 4;
  localparam int V    = 2;
  localparam int B    = 4;
  localparam int EAw  = 8;
  localparam int DAw  = 8;
  localparam int Cw   = 1;
  localparam int Fpay = 32;
  localparam int LENw = 8;
  localparam int CW   = $clog2(B) + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [EAw-1:0]       src_e_addr;
  logic [N-1:0]         req;
  logic [N*LENw-1:0]    req_len;
  logic [N*DAw-1:0]     req_dest;
  logic [N*Cw-1:0]      req_class;
  logic [N*V-1:0]       req_vc;
  logic [N*Fpay-1:0]    req_data;
  logic [V-1:0]         credit_in;
  logic [N-1:0]         ack;
  logic [N-1:0]         data_rd;
  logic [EAw-1:0]       hdr_src_e_addr;
  logic [DAw-1:0]       hdr_dest;
  logic [Cw-1:0]        hdr_class;
  logic [V-1:0]         flit_vc;
  logic                 flit_wr;
  logic                 flit_hdr;
  logic                 flit_tail;
  logic [Fpay-1:0]      flit_payload;
  logic                 busy;
  logic [V*CW-1:0]      credit_cnt;

  logic [LENw-1:0]      s_len   [N];
  logic [DAw-1:0]       s_dest  [N];
  logic [Cw-1:0]        s_class [N];
  logic [V-1:0]         s_vc    [N];
  logic [Fpay-1:0]      s_data  [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_len[g*LENw +: LENw]   = s_len[g];
    assign req_dest[g*DAw +: DAw]    = s_dest[g];
    assign req_class[g*Cw +: Cw]     = s_class[g];
    assign req_vc[g*V +: V]          = s_vc[g];
    assign req_data[g*Fpay +: Fpay]  = s_data[g];
  end

  pck_inject_sched #(
    .N(N), .V(V), .B(B), .EAw(EAw), .DAw(DAw), .Cw(Cw), .Fpay(Fpay), .LENw(LENw)
  ) dut (
    .clk(clk), .reset(reset), .src_e_addr(src_e_addr), .req(req), .req_len(req_len),
    .req_dest(req_dest), .req_class(req_class), .req_vc(req_vc), .req_data(req_data),
    .credit_in(credit_in), .ack(ack), .data_rd(data_rd), .hdr_src_e_addr(hdr_src_e_addr),
    .hdr_dest(hdr_dest), .hdr_class(hdr_class), .flit_vc(flit_vc), .flit_wr(flit_wr),
    .flit_hdr(flit_hdr), .flit_tail(flit_tail), .flit_payload(flit_payload), .busy(busy),
    .credit_cnt(credit_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int cred_of(input int v);
    return int'(credit_cnt[v*CW +: CW]);
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic [V-1:0] c);
    @(negedge clk);
    req       = r;
    credit_in = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req = '0; credit_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Directed vector table for source 0 (dest 0x12, vc 01).
  typedef struct {
    logic [N-1:0]    req;
    logic [LENw-1:0] len;
    logic [V-1:0]    cin;
    logic [N-1:0]    ack;
    logic            wr;
    logic            hdr;
    logic            tail;
    logic [N-1:0]    rd;
    logic            busy;
    int              cred0;
    logic [DAw-1:0]  dest;
  } vec_t;

  vec_t tbl [13];

  // Reference model: packet-level view (owner, flits sent of len) plus integer credit counts.
  int             m_busy, m_owner, m_len, m_sent, m_rr;
  int             m_cred [V];
  logic [V-1:0]   m_vc;
  logic [DAw-1:0] m_dest;
  logic [Cw-1:0]  m_class;
  logic [EAw-1:0] m_eaddr;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_len = 0; m_sent = 0; m_rr = 0;
    m_vc = '0; m_dest = '0; m_class = '0; m_eaddr = '0;
    for (int v = 0; v < V; v++) m_cred[v] = B;
  endtask

  task automatic model_cycle();
    logic [N-1:0] e_ack, e_rd;
    logic         e_wr, e_hdr, e_tail;
    logic [V*CW-1:0] e_cred;
    int win;
    bit found;
    e_ack = '0; e_rd = '0; e_wr = 1'b0; e_hdr = 1'b0; e_tail = 1'b0;
    win = 0; found = 1'b0;
    if (m_busy == 0) begin
      if (reset) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req[(m_rr + k) % N]) begin
            win = (m_rr + k) % N;
            found = 1'b1;
          end
        end
        if (found) e_ack[win] = 1'b1;
      end
    end else begin
      for (int v = 0; v < V; v++) if (m_vc[v] && m_cred[v] > 0) e_wr = 1'b1;
      if (e_wr) begin
        e_rd[m_owner] = 1'b1;
        e_hdr  = (m_sent == 0);
        e_tail = (m_sent == m_len - 1);
      end
    end
    for (int v = 0; v < V; v++) e_cred[v*CW +: CW] = CW'(m_cred[v]);

    check("rnd ack", ack, e_ack);
    check("rnd data_rd", data_rd, e_rd);
    check("rnd flit_wr", flit_wr, e_wr);
    check("rnd flit_hdr", flit_hdr, e_hdr);
    check("rnd flit_tail", flit_tail, e_tail);
    check("rnd busy", busy, m_busy != 0);
    check("rnd credit_cnt", credit_cnt, e_cred);
    check("rnd hdr_dest", hdr_dest, m_dest);
    check("rnd hdr_class", hdr_class, m_class);
    check("rnd hdr_src_e_addr", hdr_src_e_addr, m_eaddr);
    check("rnd flit_vc", flit_vc, m_vc);
    if (e_wr) check("rnd flit_payload", flit_payload, s_data[m_owner]);

    if (!reset) begin
      model_reset();
    end else begin
      for (int v = 0; v < V; v++) begin
        m_cred[v] = m_cred[v] - int'(e_wr && m_vc[v]) + int'(credit_in[v]);
        if (m_cred[v] > B) m_cred[v] = B;
      end
      if (m_busy == 0 && found) begin
        m_busy  = 1; m_owner = win; m_sent = 0;
        m_len   = (s_len[win] == '0) ? 1 : int'(s_len[win]);
        m_dest  = s_dest[win]; m_class = s_class[win]; m_vc = s_vc[win];
        m_eaddr = src_e_addr;
      end else if (e_wr) begin
        m_sent++;
        if (m_sent == m_len) begin
          m_busy = 0;
          m_rr   = (m_owner + 1) % N;
        end
      end
    end
  endtask

  initial begin
    int rd_count;
    logic [N-1:0] order_oh [6];

    reset = 1'b0; req = '0; credit_in = '0; src_e_addr = 8'hA5;
    for (int i = 0; i < N; i++) begin
      s_len[i] = 8'd1; s_dest[i] = DAw'(8'h40 + i); s_class[i] = '0;
      s_vc[i] = 2'b01; s_data[i] = 32'hD000_0000 + i;
    end
    s_dest[0] = 8'h12; s_class[0] = 1'b1;

    tbl[0]  = '{4'b0001, 8'd1, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4, 8'h00};
    tbl[1]  = '{4'b0000, 8'd1, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 4, 8'h12};
    tbl[2]  = '{4'b0000, 8'd1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3, 8'h12};
    tbl[3]  = '{4'b0001, 8'd0, 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3, 8'h12};
    tbl[4]  = '{4'b0000, 8'd0, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 4, 8'h12};
    tbl[5]  = '{4'b0000, 8'd0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4, 8'h12};
    tbl[6]  = '{4'b0001, 8'd2, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4, 8'h12};
    tbl[7]  = '{4'b0001, 8'd2, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 4, 8'h12};
    tbl[8]  = '{4'b0001, 8'd2, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 3, 8'h12};
    tbl[9]  = '{4'b0001, 8'd2, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2, 8'h12};
    tbl[10] = '{4'b0000, 8'd2, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 2, 8'h12};
    tbl[11] = '{4'b0000, 8'd2, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 1, 8'h12};
    tbl[12] = '{4'b0000, 8'd2, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 8'h12};

    // Reset state.
    do_reset();
    check("reset busy", busy, 1'b0);
    check("reset flit_wr", flit_wr, 1'b0);
    check("reset ack", ack, '0);
    check("reset hdr_dest", hdr_dest, '0);
    check("reset flit_vc", flit_vc, '0);
    for (int v = 0; v < V; v++) check("reset credit", cred_of(v), B);

    // Vector table: single flit, len 0 with simultaneous credit, back-to-back spacing.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req = tbl[i].req; credit_in = tbl[i].cin; s_len[0] = tbl[i].len;
      #1;
      check($sformatf("tbl%0d ack", i), ack, tbl[i].ack);
      check($sformatf("tbl%0d flit_wr", i), flit_wr, tbl[i].wr);
      check($sformatf("tbl%0d flit_hdr", i), flit_hdr, tbl[i].hdr);
      check($sformatf("tbl%0d flit_tail", i), flit_tail, tbl[i].tail);
      check($sformatf("tbl%0d data_rd", i), data_rd, tbl[i].rd);
      check($sformatf("tbl%0d busy", i), busy, tbl[i].busy);
      check($sformatf("tbl%0d credit0", i), cred_of(0), tbl[i].cred0);
      check($sformatf("tbl%0d hdr_dest", i), hdr_dest, tbl[i].dest);
      if (tbl[i].wr) check($sformatf("tbl%0d payload", i), flit_payload, s_data[0]);
    end
    check("tbl hdr_class", hdr_class, 1'b1);
    check("tbl hdr_src_e_addr", hdr_src_e_addr, 8'hA5);

    // Credit stall on vc 10: drain to one credit, then a 3-flit packet waits on returns.
    do_reset();
    s_len[0] = 8'd3; s_vc[0] = 2'b10;
    drive(4'b0001, 2'b00); check("stall pre ack", ack, 4'b0001);
    drive(4'b0000, 2'b00); drive(4'b0000, 2'b00); drive(4'b0000, 2'b00);
    drive(4'b0000, 2'b00); check("stall credit1 drained", cred_of(1), 1);
    drive(4'b0001, 2'b00); check("stall ack", ack, 4'b0001);
    drive(4'b0000, 2'b00); check("stall hdr wr", flit_wr, 1'b1); check("stall hdr flag", flit_hdr, 1'b1);
    drive(4'b0000, 2'b00); check("stall wait wr", flit_wr, 1'b0); check("stall wait rd", data_rd, '0);
    check("stall wait busy", busy, 1'b1);
    drive(4'b0000, 2'b10); check("stall credit edge wr", flit_wr, 1'b0);
    drive(4'b0000, 2'b00); check("stall body wr", flit_wr, 1'b1); check("stall body tail", flit_tail, 1'b0);
    check("stall body rd", data_rd, 4'b0001);
    drive(4'b0000, 2'b10); check("stall wait2 wr", flit_wr, 1'b0);
    drive(4'b0000, 2'b00); check("stall tail wr", flit_wr, 1'b1); check("stall tail flag", flit_tail, 1'b1);
    drive(4'b0000, 2'b00); check("stall done busy", busy, 1'b0);
    s_vc[0] = 2'b01;

    // Round-robin fairness over req=1011 with two-flit packets.
    do_reset();
    for (int i = 0; i < N; i++) s_len[i] = 8'd2;
    order_oh[0] = 4'b0001; order_oh[1] = 4'b0010; order_oh[2] = 4'b1000;
    order_oh[3] = 4'b0001; order_oh[4] = 4'b0010; order_oh[5] = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      drive(4'b1011, 2'b00);
      check($sformatf("rr%0d ack", k), ack, order_oh[k]);
      drive(4'b1011, 2'b01);
      check($sformatf("rr%0d hdr", k), {flit_wr, flit_hdr, flit_tail}, 3'b110);
      check($sformatf("rr%0d hdr rd", k), data_rd, order_oh[k]);
      drive(4'b1011, 2'b01);
      check($sformatf("rr%0d tail", k), {flit_wr, flit_hdr, flit_tail}, 3'b101);
      check($sformatf("rr%0d tail rd", k), data_rd, order_oh[k]);
    end
    check("rr credit0 steady", cred_of(0), B);

    // Reset mid-packet clears the pointer and credits.
    do_reset();
    s_len[1] = 8'd1; s_len[0] = 8'd5;
    drive(4'b0010, 2'b00); check("rst src1 ack", ack, 4'b0010);
    drive(4'b0000, 2'b00); check("rst src1 tail", flit_tail, 1'b1);
    drive(4'b0001, 2'b00); check("rst src0 ack", ack, 4'b0001);
    drive(4'b0000, 2'b00); check("rst src0 hdr", flit_hdr, 1'b1);
    drive(4'b0000, 2'b00); check("rst src0 body", flit_wr, 1'b1);
    @(negedge clk); reset = 1'b0; req = '0; #1;
    @(negedge clk); reset = 1'b1; #1;
    check("rst busy", busy, 1'b0);
    check("rst flit_wr", flit_wr, 1'b0);
    check("rst credit0", cred_of(0), B);
    check("rst credit1", cred_of(1), B);
    drive(4'b0101, 2'b00); check("rst pointer zero", ack, 4'b0001);
    do_reset();
    drive(4'b0100, 2'b00); check("rst src2 ack", ack, 4'b0100);
    drive(4'b0000, 2'b00); check("rst src2 hdr rd", data_rd, 4'b0100);

    // Request dropped after ack: the latched length still completes.
    do_reset();
    s_len[1] = 8'd4;
    drive(4'b0010, 2'b00); check("drop ack", ack, 4'b0010);
    rd_count = 0;
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, 2'b00);
      if (data_rd == 4'b0010) rd_count++;
      check($sformatf("drop flit%0d wr", k), flit_wr, 1'b1);
      check($sformatf("drop flit%0d tail", k), flit_tail, k == 3);
      check($sformatf("drop flit%0d payload", k), flit_payload, s_data[1]);
    end
    check("drop data_rd pulses", rd_count, 4);
    drive(4'b0000, 2'b00); check("drop idle", busy, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) begin
        s_len[i]   = LENw'($urandom_range(0, 4));
        s_dest[i]  = DAw'($urandom);
        s_class[i] = Cw'($urandom);
        s_vc[i]    = V'(1) << $urandom_range(0, V - 1);
        s_data[i]  = $urandom;
      end
      req = N'($urandom) & N'($urandom);
      for (int v = 0; v < V; v++)
        credit_in[v] = (m_cred[v] < B) && ($urandom_range(0, 2) == 0);
      #1;
      model_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
